// File: rtl/audio_adc_i2s_capture_ctrl.sv
// I2S ADC capture: synchronises codec pins, deserialises L/R samples into a pair FIFO,
// and exposes it over Avalon-MM. Optional irq via `AUDIO_ADC_CAPTURE_IRQ_EN.
module audio_adc_i2s_capture_ctrl #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
`ifdef AUDIO_ADC_CAPTURE_IRQ_EN
    output logic        irq,
`endif
    input  logic        adc_bclk,
    input  logic        adc_lrclk,
    input  logic        adc_dat
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DELAY, S_SHIFT, S_WAIT} state_t;

    logic bclk_s1, bclk_s2, bclk_d;
    logic lr_s1, lr_s2, lr_d;
    logic dat_s1, dat_s2;
    logic bclk_rise, lr_rise, lr_fall, lr_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {bclk_s1, bclk_s2, bclk_d} <= '0;
            {lr_s1, lr_s2, lr_d}       <= '0;
            {dat_s1, dat_s2}           <= '0;
        end else begin
            bclk_s1 <= adc_bclk;  bclk_s2 <= bclk_s1; bclk_d <= bclk_s2;
            lr_s1   <= adc_lrclk; lr_s2   <= lr_s1;   lr_d   <= lr_s2;
            dat_s1  <= adc_dat;   dat_s2  <= dat_s1;
        end
    end

    assign bclk_rise = bclk_s2 & ~bclk_d;
    assign lr_rise   = lr_s2 & ~lr_d;
    assign lr_fall   = ~lr_s2 & lr_d;
    assign lr_edge   = lr_rise | lr_fall;

    state_t                state, state_n;
    logic                  chan, chan_n;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg, sh_next, left_q;
    logic                  cnt_clr, shift_en, word_done, err, push;

    logic                  enable, frame_err, overflow;
    logic [7:0]            thr;
    logic                  wr_ctrl, clear, pop, do_push;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         level;
    logic                  empty, full;

    assign sh_next = {shreg[DATA_WIDTH-2:0], dat_s2};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            chan  <= 1'b0;
        end else begin
            state <= state_n;
            chan  <= chan_n;
        end
    end

    always_comb begin
        state_n   = state;
        chan_n    = chan;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
        err       = 1'b0;
        if (!enable) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_n = S_SYNC;
                S_SYNC: if (lr_fall) begin
                    state_n = S_DELAY;
                    chan_n  = 1'b0;
                end
                S_DELAY: begin
                    if (lr_edge) begin
                        err     = 1'b1;
                        state_n = S_SYNC;
                    end else if (bclk_rise) begin
                        cnt_clr = 1'b1;
                        state_n = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (lr_edge) begin
                        err     = 1'b1;
                        state_n = S_SYNC;
                    end else if (bclk_rise) begin
                        shift_en = 1'b1;
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                            word_done = 1'b1;
                            state_n   = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!chan && lr_rise) begin
                        state_n = S_DELAY;
                        chan_n  = 1'b1;
                    end else if (chan && lr_fall) begin
                        state_n = S_DELAY;
                        chan_n  = 1'b0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // The pair is pushed as soon as the right word completes so FIFO latency
    // does not depend on how many padding bits follow in the slot.
    assign push = word_done & chan;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            left_q  <= '0;
        end else begin
            if (cnt_clr)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + CW'(1);
            if (shift_en)
                shreg <= sh_next;
            if (word_done && !chan)
                left_q <= sh_next;
        end
    end

    assign wr_ctrl = write && (address == 2'd3);
    assign clear   = wr_ctrl && writedata[1];
    assign empty   = (level == '0);
    assign full    = (level == LW'(FIFO_DEPTH));
    assign pop     = read && (address == 2'd2) && !empty;
    assign do_push = push && !full;

    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= {left_q, sh_next};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !pop)
                level <= level + LW'(1);
            else if (pop && !do_push)
                level <= level - LW'(1);
            if (push && full)
                overflow <= 1'b1;
            if (err)
                frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            enable <= 1'b0;
        else if (wr_ctrl)
            enable <= writedata[0];
    end

`ifdef AUDIO_ADC_CAPTURE_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr <= '0;
            irq <= 1'b0;
        end else begin
            if (wr_ctrl)
                thr <= writedata[23:16];
            irq <= enable && (thr != '0) && (level >= LW'(thr));
        end
    end
`else
    assign thr = '0;
`endif

    logic                  unused_wdata;
    logic [2*DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] head_left, head_right;
    logic [31:0]           status, control, rd_val;

    assign unused_wdata = ^writedata;
    assign head       = mem[rd_ptr];
    assign head_left  = head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign head_right = head[DATA_WIDTH-1:0];
    assign status     = {19'd0, frame_err, overflow, full, empty, 9'(level)};
    assign control    = {8'd0, thr, 14'd0, 1'b0, enable};

    always_comb begin
        rd_val = '0;
        case (address)
            2'd0: rd_val = status;
            2'd1: rd_val = empty ? '0 : 32'($signed(head_left));
            2'd2: rd_val = empty ? '0 : 32'($signed(head_right));
            2'd3: rd_val = control;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata <= '0;
        else if (read)
            readdata <= rd_val;
    end

endmodule

// File: tb/tb_audio_adc_i2s_capture_ctrl.sv
// Scoreboard bench for audio_adc_i2s_capture_ctrl: directed I2S frames and Avalon
// register reads; expected read data is queued and checked by a separate monitor.
module tb_audio_adc_i2s_capture_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        adc_bclk = 1'b0;
    logic        adc_lrclk = 1'b1;
    logic        adc_dat = 1'b0;
    logic        irq_w;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        rd_vld = 1'b0;

    audio_adc_i2s_capture_ctrl #(
        .DATA_WIDTH(24),
        .FIFO_DEPTH(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
`ifdef AUDIO_ADC_CAPTURE_IRQ_EN
        .irq       (irq_w),
`endif
        .adc_bclk  (adc_bclk),
        .adc_lrclk (adc_lrclk),
        .adc_dat   (adc_dat)
    );

`ifndef AUDIO_ADC_CAPTURE_IRQ_EN
    assign irq_w = 1'b0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) rd_vld <= read;

    // Monitor: readdata is valid the cycle after a read strobe.
    always @(negedge clk) begin
        if (rd_vld) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read: got %08h, no expected value queued", readdata);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (readdata !== e) begin
                    n_err++;
                    $display("FAIL %s: got %08h expected %08h", nm, readdata, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string nm);
        @(posedge clk); #1;
        read = 1'b1; address = a;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk); #1;
        read = 1'b0;
    endtask

    // 64 BCLK periods per frame, 24 data bits MSB-first after a one-bit delay.
    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int left_len);
        for (int i = 0; i < 64; i++) begin
            adc_bclk  = 1'b0;
            adc_lrclk = (i < left_len) ? 1'b0 : 1'b1;
            if (i >= 1 && i <= 24)
                adc_dat = l[24 - i];
            else if (i >= left_len + 1 && i <= left_len + 24)
                adc_dat = r[24 - (i - left_len)];
            else
                adc_dat = 1'b0;
            #40;
            adc_bclk = 1'b1;
            #40;
        end
    endtask

    initial begin
        #3;
        #50 reset = 1'b0;
        repeat (3) @(posedge clk);

        // Reset asserted mid-frame
        bus_write(2'd3, 32'h1);
        fork
            send_frame(24'h111111, 24'h222222, 32);
            begin
                #2000;
                reset = 1'b1;
                #25;
                check("reset_readdata", readdata, 32'h0);
                check("reset_irq", {31'd0, irq_w}, 32'h0);
                reset = 1'b0;
            end
        join
        bus_read(2'd0, 32'h200, "reset_status");
        bus_read(2'd3, 32'h0, "reset_control");

        // Single frame capture
        bus_write(2'd3, 32'h1);
        send_frame(24'h123456, 24'hABCDEF, 32);
        bus_read(2'd0, 32'h001, "one_status");
        bus_read(2'd1, 32'h00123456, "one_left");
        bus_read(2'd2, 32'hFFABCDEF, "one_right");
        bus_read(2'd0, 32'h200, "one_status_after");
        bus_read(2'd2, 32'h0, "empty_right");
        bus_read(2'd0, 32'h200, "empty_pop_status");
        bus_read(2'd3, 32'h1, "control_enabled");
        bus_write(2'd0, 32'hFFFFFFFF);
        bus_read(2'd0, 32'h200, "status_write_ignored");

        // Overflow: 17 frames into a 16-deep FIFO
        for (int k = 1; k <= 17; k++)
            send_frame(24'h100000 + 24'(k), 24'h800000 + 24'(k), 32);
        bus_read(2'd0, 32'hC10, "full_status");
        bus_read(2'd1, 32'h00100001, "full_head_left");

        // Clear while full keeps enable
        bus_write(2'd3, 32'h3);
        bus_read(2'd0, 32'h200, "clear_status");
        bus_read(2'd3, 32'h1, "clear_control");

        // Frame error: LR rises after 10 left bits
        send_frame(24'hFFFFFF, 24'hFFFFFF, 11);
        bus_read(2'd0, 32'h1200, "ferr_status");
        send_frame(24'h0A0B0C, 24'h7FFFFF, 32);
        bus_read(2'd0, 32'h1001, "ferr_recover_status");
        bus_read(2'd1, 32'h000A0B0C, "ferr_left");
        bus_read(2'd2, 32'h007FFFFF, "ferr_right");
        bus_read(2'd0, 32'h1200, "ferr_empty_status");

`ifdef AUDIO_ADC_CAPTURE_IRQ_EN
        bus_write(2'd3, 32'h0004_0001);
        bus_read(2'd3, 32'h0004_0001, "irq_control");
        for (int k = 1; k <= 3; k++)
            send_frame(24'h000100 + 24'(k), 24'h000200 + 24'(k), 32);
        repeat (2) @(posedge clk); #1;
        check("irq_below_thr", {31'd0, irq_w}, 32'h0);
        send_frame(24'h000104, 24'h000204, 32);
        check("irq_at_thr", {31'd0, irq_w}, 32'h1);
        bus_read(2'd2, 32'h00000201, "irq_pop_right");
        repeat (2) @(posedge clk); #1;
        check("irq_after_pop", {31'd0, irq_w}, 32'h0);
`else
        bus_write(2'd3, 32'h0004_0001);
        bus_read(2'd3, 32'h1, "thr_absent_control");
`endif

        repeat (5) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
